vdiv_lane_seq: RTL and testbench
================================

Name: vdiv_lane_seq

Overview:
- Sequential controller for the vector ALU unsigned divide (FS = 5'h03).
- Time-shares one iterative 8-bit restoring divider across four 8-bit lanes of a 32-bit vector operand.
- Produces per-lane quotient (VY_lo) and remainder (VY_hi), plus divide-by-zero flags.
- Sits beside the vector ALU; the CPU control unit stalls on busy and samples results on done.

Parameters:
- LANES, 4, number of byte lanes per vector operand.
- W, 8, lane width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; accepted only in IDLE with FS == 5'h03.
- FS  input  5  ALU function select.
- S  input  LANES*W  dividend vector; lane i = S[i*W +: W].
- T  input  LANES*W  divisor vector; same lane mapping.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle completion pulse.
- VY_lo  output  LANES*W  per-lane quotients.
- VY_hi  output  LANES*W  per-lane remainders.
- dz  output  LANES  per-lane divisor-was-zero flags.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low (reset_n).
- Reset (reset_n low at a clk edge): state = IDLE; busy, done, VY_lo, VY_hi, dz all 0; lane index 0.
- Reset mid-operation aborts the divide; no done pulse is issued.
- Operand capture: on accept, S and T are registered; later changes on S/T are ignored.
- Ignored starts: start with FS != 5'h03 is ignored; start while busy is ignored.
- Arithmetic: unsigned, restoring, one quotient bit per cycle.
  - Partial remainder register is W+1 bits.
  - Each ITER cycle: rem = {rem[W-1:0], dividend msb}; shift dividend/quotient left.
  - If rem >= divisor: rem -= divisor and set quotient lsb to 1.
- FSM states: IDLE -> LOAD -> ITER (W cycles) -> STORE -> next lane LOAD, or DONE after lane LANES-1 -> IDLE.
  - LOAD: selects lane idx; clears rem; loads dividend/divisor.
  - STORE: writes quotient/remainder into lane idx of VY_lo/VY_hi; sets dz[idx] if divisor == 0; increments idx.
  - DONE: done = 1 for one cycle, busy = 0; returns to IDLE.
- Latency: accept edge to done = LANES*(W+2)+1 = 41 cycles at defaults. Lanes are processed in order 0..LANES-1.
- Divisor zero: the restoring algorithm naturally yields quotient = all ones (8'hFF) and remainder = dividend; dz[idx] = 1.
- Output hold: outputs hold their last result until the next accepted start.
  - On accept, dz clears to 0.
  - VY_lo/VY_hi update lane-by-lane as each lane completes, so they are valid only at done.
- Back-to-back: start asserted in the cycle after done, with state back in IDLE, is accepted.

Optional Feature:
- Macro: VDIV_ZERO_SKIP_EN.
- Defined: in LOAD, a lane with divisor == 0 goes directly to STORE.
  - Result is 8'hFF / dividend, dz set.
  - Saves W cycles per zero lane: latency = 41 - 8*(number of zero lanes).
- Undefined: every lane runs the full W iterations and latency is fixed at 41.
- Results are identical either way.

Decomposition:
- Shared package: FS_DIV = 5'h03 constant; state encoding (IDLE, LOAD, ITER, STORE, DONE); LANES/W defaults.
- One sub-module: div8_iter, the single-lane iterative datapath.
  - Inputs: load, step, dividend, divisor.
  - Outputs: quotient, remainder, dz.
  - The controller owns the FSM, lane index, iteration counter and output packing.

Test Plan:
- Basic divide: reset_n low 2 cycles, then release; start, FS=03, S=0x640FFF07, T=0x07031002.
  - Expect done at accept+41, VY_lo=0x0E050F03, VY_hi=0x02000F01, dz=0000, busy high 40 cycles.
- Zero divisors: S=0x12345678, T=0x01000300.
  - Expect VY_lo=0x12FF1CFF, VY_hi=0x00340278, dz=0101.
  - done at +41 without VDIV_ZERO_SKIP_EN, +25 with it.
- Ignored start: start with FS=5'h02 -> no busy, outputs unchanged. Second start mid-operation -> ignored, single done at +41.
- Reset mid-operation: reset_n low at cycle 15 after accept -> next cycle busy=0, outputs 0; no done pulse observed afterward.
- Back-to-back: start again the cycle after done with S=0xFFFFFFFF, T=0x01010101.
  - Expect VY_lo=0xFFFFFFFF, VY_hi=0, dz cleared, done 41 cycles later.

Source files
------------

// File: rtl/vdiv_lane_seq_pkg.sv
// Shared constants and FSM encoding for the sequential vector lane divider.
package vdiv_lane_seq_pkg;

    localparam logic [4:0] FS_DIV    = 5'h03;
    localparam int         LANES_DEF = 4;
    localparam int         W_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_STORE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vdiv_lane_seq_div8_iter.sv
// Single-lane restoring divider datapath: load operands, then one quotient bit per step.
module div8_iter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_dz
);

    logic [W-1:0] r_rem;
    logic [W-1:0] r_dvd;
    logic [W-1:0] r_dvs;
    logic [W-1:0] r_quo;
    logic [W:0]   w_trial;
    logic         w_ge;

    // Partial remainder is W+1 bits wide here; the stored value is always below the divisor.
    assign w_trial = {r_rem, r_dvd[W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});

    // NOTE: datapath registers carry no reset; the controller always issues load before using them.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_rem <= '0;
            r_dvd <= i_dividend;
            r_dvs <= i_divisor;
            r_quo <= '0;
        end else if (i_step) begin
            r_dvd <= {r_dvd[W-2:0], 1'b0};
            if (w_ge) begin
                r_rem <= W'(w_trial - {1'b0, r_dvs});
                r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
                r_rem <= W'(w_trial);
                r_quo <= {r_quo[W-2:0], 1'b0};
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_dz        = (r_dvs == '0);

endmodule

// File: rtl/vdiv_lane_seq.sv
// Vector unsigned divide controller: one shared iterative divider walks lanes 0..LANES-1.
// Optional VDIV_ZERO_SKIP_EN: lanes with a zero divisor skip the iterations.
module vdiv_lane_seq
    import vdiv_lane_seq_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W     = W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [4:0]         FS,
    input  logic [LANES*W-1:0] S,
    input  logic [LANES*W-1:0] T,
    output logic               busy,
    output logic               done,
    output logic [LANES*W-1:0] VY_lo,
    output logic [LANES*W-1:0] VY_hi,
    output logic [LANES-1:0]   dz
);

    localparam int            IW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t             r_state;
    logic [IW-1:0]      r_idx;
    logic [CW-1:0]      r_cnt;
    logic [LANES*W-1:0] r_s;
    logic [LANES*W-1:0] r_t;

    logic [W-1:0] w_lane_dvd;
    logic [W-1:0] w_lane_dvs;
    logic [W-1:0] w_quo;
    logic [W-1:0] w_rem;
    logic [W-1:0] w_quo_st;
    logic [W-1:0] w_rem_st;
    logic         w_dz;
    logic         w_skip;

    // NOTE: defaults first so the lane mux cannot infer a latch.
    always_comb begin
        w_lane_dvd = '0;
        w_lane_dvs = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == IW'(i)) begin
                w_lane_dvd = r_s[i*W +: W];
                w_lane_dvs = r_t[i*W +: W];
            end
        end
    end

`ifdef VDIV_ZERO_SKIP_EN
    assign w_skip   = (w_lane_dvs == '0);
    assign w_quo_st = w_dz ? '1 : w_quo;
    assign w_rem_st = w_dz ? w_lane_dvd : w_rem;
`else
    assign w_skip   = 1'b0;
    assign w_quo_st = w_quo;
    assign w_rem_st = w_rem;
`endif

    div8_iter #(.W(W)) u_div (
        .clk         (clk),
        .i_load      (r_state == ST_LOAD),
        .i_step      (r_state == ST_ITER),
        .i_dividend  (w_lane_dvd),
        .i_divisor   (w_lane_dvs),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_dz        (w_dz)
    );

    // NOTE: all state and outputs use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_t     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            VY_lo   <= '0;
            VY_hi   <= '0;
            dz      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (FS == FS_DIV)) begin
                        r_s     <= S;
                        r_t     <= T;
                        r_idx   <= '0;
                        dz      <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= w_skip ? ST_STORE : ST_ITER;
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_state <= ST_STORE;
                end
                ST_STORE: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (r_idx == IW'(i)) begin
                            VY_lo[i*W +: W] <= w_quo_st;
                            VY_hi[i*W +: W] <= w_rem_st;
                            dz[i]           <= w_dz;
                        end
                    end
                    if (r_idx == IDX_LAST) begin
                        r_idx   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdiv_lane_seq.sv
// Scoreboard bench for vdiv_lane_seq: reference results come from plain per-lane / and %.
module tb_vdiv_lane_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [4:0]  FS;
    logic [31:0] S;
    logic [31:0] T;
    logic        busy;
    logic        done;
    logic [31:0] VY_lo;
    logic [31:0] VY_hi;
    logic [3:0]  dz;

    vdiv_lane_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .FS      (FS),
        .S       (S),
        .T       (T),
        .busy    (busy),
        .done    (done),
        .VY_lo   (VY_lo),
        .VY_hi   (VY_hi),
        .dz      (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;
    logic [3:0]  last_dz = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Latency counts rising edges from the accept edge through the edge that raises done.
    function automatic exp_t model(input logic [31:0] s, input logic [31:0] t);
        exp_t e;
        int   zeros = 0;
        for (int i = 0; i < 4; i++) begin
            int a = int'(s[i*8 +: 8]);
            int b = int'(t[i*8 +: 8]);
            if (b == 0) begin
                e.lo[i*8 +: 8] = 8'hFF;
                e.hi[i*8 +: 8] = 8'(a);
                e.dz[i]        = 1'b1;
                zeros++;
            end else begin
                e.lo[i*8 +: 8] = 8'(a / b);
                e.hi[i*8 +: 8] = 8'(a % b);
                e.dz[i]        = 1'b0;
            end
        end
`ifdef VDIV_ZERO_SKIP_EN
        e.lat = 41 - 8 * zeros;
`else
        e.lat = 41;
`endif
        e.acc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("vy_lo", VY_lo, e.lo);
                check("vy_hi", VY_hi, e.hi);
                check("dz", 32'(dz), 32'(e.dz));
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [31:0] s, input logic [31:0] t);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        FS    = 5'h03;
        S     = s;
        T     = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        FS    = 5'($urandom);
        S     = $urandom;
        T     = $urandom;
        e     = model(s, t);
        e.acc = cyc;
        sb.push_back(e);
        last_lo = e.lo;
        last_hi = e.hi;
        last_dz = e.dz;
    endtask

    task automatic wait_done(output int busy_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) busy_cnt++;
        end
        if (!seen) check("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] s, input logic [31:0] t);
        int   bc;
        exp_t e;
        e = model(s, t);
        issue(s, t);
        wait_done(bc);
        check(name, 32'(bc), 32'(e.lat - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int          bc;
        logic [31:0] rs;
        logic [31:0] rt;

        reset_n = 1'b0;
        start   = 1'b0;
        FS      = 5'h00;
        S       = '0;
        T       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vy_lo", VY_lo, 32'd0);
        check("rst_vy_hi", VY_hi, 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        reset_n = 1'b1;

        run_op("basic_busy", 32'h640FFF07, 32'h07031002);
        check("basic_lo_const", last_lo, 32'h0E050F03);
        run_op("zero_busy", 32'h12345678, 32'h01000300);
        check("zero_lo_const", last_lo, 32'h12FF1CFF);

        // A start carrying a different function code must be ignored.
        @(negedge clk);
        start = 1'b1;
        FS    = 5'h02;
        S     = 32'hDEADBEEF;
        T     = 32'h01020304;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("ign_fs_busy", 32'(busy), 32'd0);
        check("ign_fs_lo", VY_lo, last_lo);
        check("ign_fs_hi", VY_hi, last_hi);
        check("ign_fs_dz", 32'(dz), 32'(last_dz));

        // A second start while busy must not restart or queue another divide.
        issue(32'hA5C3F00D, 32'h0B070305);
        repeat (10) @(negedge clk);
        start = 1'b1;
        FS    = 5'h03;
        S     = 32'h11111111;
        T     = 32'h02020202;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        repeat (45) @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            rs = $urandom;
            rt = $urandom;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(3) == 0) rt[i*8 +: 8] = 8'h00;
            run_op("rand_busy", rs, rt);
        end

        // Reset 15 cycles into an operation aborts it with no done pulse.
        issue(32'h87654321, 32'h03050709);
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_vy_lo", VY_lo, 32'd0);
        check("abort_vy_hi", VY_hi, 32'd0);
        check("abort_dz", 32'(dz), 32'd0);
        repeat (50) @(negedge clk);

        // Back-to-back: the second start lands in the idle cycle right after done.
        run_op("b2b_first_busy", 32'h12345678, 32'h01000300);
        run_op("b2b_second_busy", 32'hFFFFFFFF, 32'h01010101);
        check("b2b_hi", VY_hi, 32'd0);
        check("b2b_dz", 32'(dz), 32'd0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
